vga_pixel_sink: RTL and testbench

Receiving end of the game's pixel-plot interface: accepts `x`/`y`/`color` writes qualified by `plot` into a 160x120, 3-bit frame buffer and scans it out continuously as 640x480@60 VGA with 4x pixel replication. It sits between the game datapath and the DAC pins and replaces the vendor VGA adapter. A built-in clear engine fills the buffer with a background colour after reset or on request.

---
 rtl/vga_sink_pkg.sv | 41 ++++
 rtl/vga_timing.sv | 71 +++++++
 rtl/vga_pixel_sink.sv | 211 +++++++++++++++++++++
 tb/tb_vga_pixel_sink.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_sink_pkg.sv
// Shared constants, types and helpers for the VGA pixel sink.
// 160x120 3-bit frame buffer, 640x480@60 scan-out with 4x replication.
package vga_sink_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = 19200;

  // Horizontal timing in pixel ticks.
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  // Vertical timing in lines.
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_FIRST = H_VIS + H_FP;
  localparam int H_SYNC_LAST  = H_VIS + H_FP + H_SYNC - 1;
  localparam int V_SYNC_FIRST = V_VIS + V_FP;
  localparam int V_SYNC_LAST  = V_VIS + V_FP + V_SYNC - 1;

  typedef logic [2:0] color_t;

  typedef enum logic [1:0] {
    CLR_RESET = 2'd0,
    CLR_IDLE  = 2'd1,
    CLR_CLEAR = 2'd2
  } clr_state_e;

  // Linear buffer address row*160 + col, built from shifts.
  function automatic logic [14:0] fb_addr(input logic [7:0] col, input logic [6:0] row);
    return {1'b0, row, 7'b0000000} + {3'b000, row, 5'b00000} + {7'b0000000, col};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel divider, raster counters and raw (unregistered) sync/blank decode.
module vga_timing
  import vga_sink_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       pix_tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hs_n,
  output logic       vs_n,
  output logic       visible
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             tick_s;

  // Next-state for the divider and the raster position.
  always_comb begin
    tick_s = (div_q == DIV_LAST);
    h_d    = h_q;
    v_d    = v_q;
    if (tick_s) begin
      div_d = '0;
      if (h_q == 10'(H_TOTAL - 1)) begin
        h_d = 10'd0;
        if (v_q == 10'(V_TOTAL - 1)) begin
          v_d = 10'd0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Divider and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= '0;
      h_q   <= 10'd0;
      v_q   <= 10'd0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Raw sync and visible-region decode from the current position.
  always_comb begin
    hs_n    = !((h_q >= 10'(H_SYNC_FIRST)) && (h_q <= 10'(H_SYNC_LAST)));
    vs_n    = !((v_q >= 10'(V_SYNC_FIRST)) && (v_q <= 10'(V_SYNC_LAST)));
    visible = (h_q < 10'(H_VIS)) && (v_q < 10'(V_VIS));
  end

  assign pix_tick = tick_s;
  assign hcount   = h_q;
  assign vcount   = v_q;

endmodule

// File: rtl/vga_pixel_sink.sv
// Pixel-plot receiver: frame buffer, clear engine, write mux and scan-out.
// Optional feature macro: VGA_SINK_CLIP_EN (drop out-of-range plots, flag clip_err).
module vga_pixel_sink
  import vga_sink_pkg::*;
#(
  parameter int       CLK_DIV    = 2,
  parameter logic [2:0] BG_COLOR = 3'b000,
  parameter bit       INIT_CLEAR = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] color,
  input  logic       clear,
  output logic       busy,
  output logic       clip_err,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       pix_tick
);

  // Raster timing
  logic       tick_s, hs_raw_s, vs_raw_s, visible_s;
  logic [9:0] hcount_s, vcount_s;

  vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
    .clk     (clk),
    .resetn  (resetn),
    .pix_tick(tick_s),
    .hcount  (hcount_s),
    .vcount  (vcount_s),
    .hs_n    (hs_raw_s),
    .vs_n    (vs_raw_s),
    .visible (visible_s)
  );

  // Clear engine
  clr_state_e  state_q, state_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic        busy_q, busy_d;
  logic        clearing_s;

  // Clear FSM next-state: walk every address once, then fall back to idle.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLR_RESET: begin
        clr_addr_d = 15'd0;
        if (INIT_CLEAR || clear) begin
          state_d = CLR_CLEAR;
        end else begin
          state_d = CLR_IDLE;
        end
      end
      CLR_IDLE: begin
        clr_addr_d = 15'd0;
        if (clear) begin
          state_d = CLR_CLEAR;
        end else begin
          state_d = CLR_IDLE;
        end
      end
      CLR_CLEAR: begin
        if (clr_addr_q == 15'(FB_DEPTH - 1)) begin
          state_d    = CLR_IDLE;
          clr_addr_d = 15'd0;
        end else begin
          clr_addr_d = clr_addr_q + 15'd1;
        end
      end
      default: begin
        state_d    = CLR_IDLE;
        clr_addr_d = 15'd0;
      end
    endcase
    busy_d = (state_d == CLR_CLEAR);
  end

  // Clear FSM state, address and registered busy flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= CLR_RESET;
      clr_addr_q <= 15'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  // Write mux and range check
  logic        wr_en_s, plot_ok_s;
  logic [14:0] wr_addr_s;
  color_t      wr_data_s;
  logic        clip_err_q, clip_err_d;

  // Clear engine owns the write port; plots arriving meanwhile are dropped.
  always_comb begin
    clearing_s = (state_q == CLR_CLEAR);
`ifdef VGA_SINK_CLIP_EN
    plot_ok_s  = plot && !clearing_s && (x < 8'(FB_W)) && (y < 7'(FB_H));
    clip_err_d = clip_err_q || (plot && !clearing_s && ((x >= 8'(FB_W)) || (y >= 7'(FB_H))));
`else
    plot_ok_s  = plot && !clearing_s;
    clip_err_d = 1'b0;
`endif
    if (clearing_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_addr_q;
      wr_data_s = BG_COLOR;
    end else begin
      wr_en_s   = plot_ok_s;
      wr_addr_s = fb_addr(x, y);
      wr_data_s = color;
    end
  end

  // Sticky clip flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clip_err_q <= 1'b0;
    end else begin
      clip_err_q <= clip_err_d;
    end
  end

  // Frame memory
  color_t      mem_q [0:FB_DEPTH-1];
  color_t      rd_data_q;
  logic [14:0] rd_addr_s;

  assign rd_addr_s = (({5'b00000, vcount_s} >> 2) * 15'd160) + ({5'b00000, hcount_s} >> 2);

  // Simple dual-port RAM: addresses past the end are ignored; read returns old data.
  always_ff @(posedge clk) begin
    if (wr_en_s && (wr_addr_s < 15'(FB_DEPTH))) begin
      mem_q[wr_addr_s] <= wr_data_s;
    end
    if (visible_s) begin
      rd_data_q <= mem_q[rd_addr_s];
    end
  end

  // Output pipeline
  logic   hs1_q, vs1_q, vis1_q, tick1_q;
  logic   hs1_d, vs1_d, vis1_d, tick1_d;
  logic   hs2_q, vs2_q, vis2_q, tick2_q;
  logic   hs2_d, vs2_d, vis2_d, tick2_d;
  color_t rgb_q, rgb_d;

  // Stage 1 runs beside the RAM read; stage 2 blanks and registers the pins.
  always_comb begin
    hs1_d   = hs_raw_s;
    vs1_d   = vs_raw_s;
    vis1_d  = visible_s;
    tick1_d = tick_s;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
    vis2_d  = vis1_q;
    tick2_d = tick1_q;
    if (vis1_q) begin
      rgb_d = rd_data_q;
    end else begin
      rgb_d = 3'b000;
    end
  end

  // Two-stage aligned sync/blank/colour registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      vis1_q  <= 1'b0;
      tick1_q <= 1'b0;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
      vis2_q  <= 1'b0;
      tick2_q <= 1'b0;
      rgb_q   <= 3'b000;
    end else begin
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      vis1_q  <= vis1_d;
      tick1_q <= tick1_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      vis2_q  <= vis2_d;
      tick2_q <= tick2_d;
      rgb_q   <= rgb_d;
    end
  end

  assign busy        = busy_q;
  assign clip_err    = clip_err_q;
  assign vga_hs      = hs2_q;
  assign vga_vs      = vs2_q;
  assign vga_blank_n = vis2_q;
  assign pix_tick    = tick2_q;
  assign vga_r       = {8{rgb_q[2]}};
  assign vga_g       = {8{rgb_q[1]}};
  assign vga_b       = {8{rgb_q[0]}};

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Self-checking bench for vga_pixel_sink: reset values, clear timing,
// table-driven and random plots checked against a frame model on scan-out.
module tb_vga_pixel_sink;

  localparam logic [2:0] BG = 3'b010;
`ifdef VGA_SINK_CLIP_EN
  localparam bit CLIP_BUILD = 1'b1;
`else
  localparam bit CLIP_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn, plot, clear;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       busy, clip_err, vga_hs, vga_vs, vga_blank_n, pix_tick;
  logic [7:0] vga_r, vga_g, vga_b;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [2:0] fb_model [0:119][0:159];

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         row;
    int         col;
  } plot_vec_t;

  plot_vec_t tbl [5];

  always #10 clk = ~clk;

  vga_pixel_sink #(.CLK_DIV(2), .BG_COLOR(BG), .INIT_CLEAR(1'b1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .plot       (plot),
    .x          (x),
    .y          (y),
    .color      (color),
    .clear      (clear),
    .busy       (busy),
    .clip_err   (clip_err),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .pix_tick   (pix_tick)
  );

  // Clock edges since the last reset release.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  function automatic logic [27:0] out_vec();
    return {vga_hs, vga_vs, vga_blank_n, pix_tick, vga_r, vga_g, vga_b};
  endfunction

  // Expected pins k edges after release: pixel n = (k-2)/2, 800 per line.
  function automatic logic [27:0] exp_vec(int k);
    int n, h, v;
    logic vis, tk;
    logic [2:0] c;
    if (k < 2) return {1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};
    n   = (k - 2) / 2;
    h   = n % 800;
    v   = (n / 800) % 525;
    tk  = ((k - 2) % 2) == 1;
    vis = (h < 640) && (v < 480);
    c   = vis ? fb_model[v / 4][h / 4] : 3'b000;
    return {!(h >= 656 && h <= 751), !(v >= 490 && v <= 491), vis, tk,
            {8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_pins"}, {4'h0, out_vec()}, {4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_clip"}, {31'd0, clip_err}, 32'd0);
  endtask

  initial begin
    int bcount, cur_line, bad, first_h, k, ln;
    logic [27:0] e, a, fa, fe;

    resetn = 1'b0; plot = 1'b0; clear = 1'b0;
    x = 8'd0; y = 7'd0; color = 3'b000;

    for (int r = 0; r < 120; r++)
      for (int c = 0; c < 160; c++)
        fb_model[r][c] = BG;

    tbl[0] = '{8'd0,   7'd5,  3'b100, 5,  0};
    tbl[1] = '{8'd159, 7'd7,  3'b011, 7,  159};
    tbl[2] = '{8'd160, 7'd5,  3'b101, 6,  0};
    tbl[3] = '{8'd80,  7'd8,  3'b111, 8,  80};
    tbl[4] = '{8'd159, 7'd11, 3'b001, 11, 159};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_pins("reset");

    // First release: busy must rise on the first edge.
    resetn = 1'b1;
    @(negedge clk);
    check("busy_first_edge", {31'd0, busy}, 32'd1);

    // Asynchronous reset mid-clear and mid-line.
    repeat (3000) @(negedge clk);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1 check_reset_pins("async_reset");
    @(negedge clk);
    resetn = 1'b1;

    // Busy length after the restarted clear; one plot issued mid-clear.
    bcount = 0;
    for (int i = 0; i < 25000; i++) begin
      @(negedge clk);
      if (busy) bcount++;
      else if (bcount > 0) break;
      if (bcount == 5000) begin
        plot = 1'b1; x = 8'd10; y = 7'd9; color = 3'b111;
      end else begin
        plot = 1'b0;
      end
    end
    check("busy_cycles", bcount, 32'd19200);

    // Table-driven plots.
    for (int i = 0; i < 5; i++) begin
      plot = 1'b1; x = tbl[i].x; y = tbl[i].y; color = tbl[i].c;
      if (!(CLIP_BUILD && (tbl[i].x >= 8'd160 || tbl[i].y >= 7'd120)))
        fb_model[tbl[i].row][tbl[i].col] = tbl[i].c;
      @(negedge clk);
    end

    // Random plots into rows that have not been scanned yet.
    for (int i = 0; i < 40; i++) begin
      plot  = 1'b1;
      x     = 8'($urandom_range(0, 159));
      y     = 7'($urandom_range(5, 11));
      color = 3'($urandom_range(0, 7));
      fb_model[y][x] = color;
      @(negedge clk);
    end
    plot = 1'b0;
    @(negedge clk);
    check("clip_err_after_plots", {31'd0, clip_err}, {31'd0, CLIP_BUILD});

    // Scan-out of lines 13..47 compared against the model, one check per line.
    cur_line = -1; bad = 0; first_h = 0; fa = '0; fe = '0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      k  = cyc;
      ln = ((k - 2) / 2) / 800;
      if (ln != cur_line) begin
        if (cur_line >= 13) begin
          checks++;
          if (bad != 0) begin
            errors++;
            $display("FAIL scan_line_%0d: %0d bad samples, first at h=%0d got %07h expected %07h",
                     cur_line, bad, first_h, fa, fe);
          end
        end
        cur_line = ln;
        bad = 0;
        if (ln > 47) break;
      end
      if (ln >= 13) begin
        e = exp_vec(k);
        a = out_vec();
        if (a !== e) begin
          if (bad == 0) begin
            first_h = ((k - 2) / 2) % 800;
            fa = a;
            fe = e;
          end
          bad++;
        end
      end
    end
    check("scan_reached_line_48", {31'd0, (cur_line > 47)}, 32'd1);

    // Reset clears the sticky flag.
    @(negedge clk);
    resetn = 1'b0;
    #1 check("clip_err_after_reset", {31'd0, clip_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
